// File: rtl/arbitro_display_7segmentos.sv
// rtl/arbitro_display_7segmentos.sv - round-robin arbiter sharing the 7-segment display between two sources
//
// Purpose: grants the 4-digit display to source A or B, holding each owner
// for at least P_TIEMPO_MIN cycles and pre-empting it after P_TIEMPO_MAX
// cycles when the other source is waiting. Ties from idle alternate.
//
// Ports:
//   i_Reloj            system clock, rising edge
//   i_Reset            asynchronous reset, active low
//   i_Sol_A / i_Sol_B  display requests
//   i_Datos_A/B        16-bit digit buses, [3:0] = digit 0 ... [15:12] = digit 3
//   o_Conc_A/B         grants (decoded from the state register, never both 1)
//   o_Datos_0..3       registered digit nibbles for the display controller
//   o_Apagar           1 = display blank (no owner)
//   o_Fuente           last/current owner, 0 = A, 1 = B

module arbitro_display_7segmentos #(
    parameter int P_TIEMPO_MIN = 4,
    parameter int P_TIEMPO_MAX = 16
) (
    input  logic        i_Reloj,
    input  logic        i_Reset,
    input  logic        i_Sol_A,
    input  logic [15:0] i_Datos_A,
    input  logic        i_Sol_B,
    input  logic [15:0] i_Datos_B,
    output logic        o_Conc_A,
    output logic        o_Conc_B,
    output logic [3:0]  o_Datos_0,
    output logic [3:0]  o_Datos_1,
    output logic [3:0]  o_Datos_2,
    output logic [3:0]  o_Datos_3,
    output logic        o_Apagar,
    output logic        o_Fuente
);

    localparam int CW = $clog2(P_TIEMPO_MAX + 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(P_TIEMPO_MIN - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(P_TIEMPO_MAX - 1);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        SERVIR_A = 2'd1,
        SERVIR_B = 2'd2
    } estado_t;

    estado_t       state;
    estado_t       state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [15:0]   datos;
    logic [15:0]   datos_next;
    logic          apagar;
    logic          apagar_next;
    logic          fuente;
    logic          fuente_next;

    always_ff @(posedge i_Reloj or negedge i_Reset) begin
        if (!i_Reset) begin
            state  <= REPOSO;
            cnt    <= '0;
            datos  <= '0;
            apagar <= 1'b1;
            fuente <= 1'b1;   // makes A win the first tie after reset
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            datos  <= datos_next;
            apagar <= apagar_next;
            fuente <= fuente_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        datos_next  = datos;
        fuente_next = fuente;

        // Next-state selection
        case (state)
            REPOSO: begin
                if (i_Sol_A && !i_Sol_B)
                    state_next = SERVIR_A;
                else if (!i_Sol_A && i_Sol_B)
                    state_next = SERVIR_B;
                else if (i_Sol_A && i_Sol_B)
                    state_next = fuente ? SERVIR_A : SERVIR_B;
            end
            SERVIR_A: begin
                // Below the minimum hold time nothing can move the owner.
                if (cnt >= CNT_MIN) begin
                    if (i_Sol_B && (!i_Sol_A || cnt >= CNT_MAX))
                        state_next = SERVIR_B;
                    else if (!i_Sol_A && !i_Sol_B)
                        state_next = REPOSO;
                end
            end
            SERVIR_B: begin
                if (cnt >= CNT_MIN) begin
                    if (i_Sol_A && (!i_Sol_B || cnt >= CNT_MAX))
                        state_next = SERVIR_A;
                    else if (!i_Sol_B && !i_Sol_A)
                        state_next = REPOSO;
                end
            end
            default: state_next = REPOSO;
        endcase

        // Counter, data and owner bookkeeping
        if (state_next != state) begin
            cnt_next = '0;
            case (state_next)
                SERVIR_A: begin
                    datos_next  = i_Datos_A;
                    fuente_next = 1'b0;
                end
                SERVIR_B: begin
                    datos_next  = i_Datos_B;
                    fuente_next = 1'b1;
                end
                default: datos_next = '0;
            endcase
        end else if (state == SERVIR_A) begin
            if (cnt != CNT_MAX)
                cnt_next = cnt + CW'(1);
            // Live update only while the owner still requests; the
            // minimum-time tail keeps the last value shown.
            if (i_Sol_A)
                datos_next = i_Datos_A;
        end else if (state == SERVIR_B) begin
            if (cnt != CNT_MAX)
                cnt_next = cnt + CW'(1);
            if (i_Sol_B)
                datos_next = i_Datos_B;
        end

        apagar_next = (state_next == REPOSO);
    end

    assign o_Conc_A  = (state == SERVIR_A);
    assign o_Conc_B  = (state == SERVIR_B);
    assign o_Datos_0 = datos[3:0];
    assign o_Datos_1 = datos[7:4];
    assign o_Datos_2 = datos[11:8];
    assign o_Datos_3 = datos[15:12];
    assign o_Apagar  = apagar;
    assign o_Fuente  = fuente;

endmodule

// File: tb/tb_arbitro_display_7segmentos.sv
// tb/tb_arbitro_display_7segmentos.sv - self-checking bench for arbitro_display_7segmentos

module tb_arbitro_display_7segmentos;

    localparam int T_MIN = 4;
    localparam int T_MAX = 16;

    logic        clk;
    logic        rst_n;
    logic        sol_a;
    logic [15:0] datos_a;
    logic        sol_b;
    logic [15:0] datos_b;
    logic        conc_a;
    logic        conc_b;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic [3:0]  d2;
    logic [3:0]  d3;
    logic        apagar;
    logic        fuente;

    int checks;
    int errors;

    // Reference model: who owns the display, for how many cycles it has
    // been shown, what is on screen and who owned it last.
    int          m_owner;   // 0 none, 1 A, 2 B
    int          m_held;
    logic [15:0] m_data;
    logic        m_fuente;

    arbitro_display_7segmentos #(
        .P_TIEMPO_MIN(T_MIN),
        .P_TIEMPO_MAX(T_MAX)
    ) dut (
        .i_Reloj  (clk),
        .i_Reset  (rst_n),
        .i_Sol_A  (sol_a),
        .i_Datos_A(datos_a),
        .i_Sol_B  (sol_b),
        .i_Datos_B(datos_b),
        .o_Conc_A (conc_a),
        .o_Conc_B (conc_b),
        .o_Datos_0(d0),
        .o_Datos_1(d1),
        .o_Datos_2(d2),
        .o_Datos_3(d3),
        .o_Apagar (apagar),
        .o_Fuente (fuente)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] dut_vec();
        return {conc_a, conc_b, d3, d2, d1, d0, apagar, fuente};
    endfunction

    function automatic logic [19:0] model_vec();
        return {m_owner == 1, m_owner == 2, m_data, m_owner == 0, m_fuente};
    endfunction

    task automatic model_reset();
        m_owner  = 0;
        m_held   = 0;
        m_data   = 16'h0;
        m_fuente = 1'b1;
    endtask

    task automatic model_grant(input int who);
        m_owner  = who;
        m_held   = 1;
        m_data   = (who == 1) ? datos_a : datos_b;
        m_fuente = (who == 2);
    endtask

    // One clock edge of the specified behaviour, using the inputs present at the edge.
    task automatic model_edge();
        logic mine;
        logic other;
        if (m_owner == 0) begin
            if (sol_a && !sol_b)      model_grant(1);
            else if (!sol_a && sol_b) model_grant(2);
            else if (sol_a && sol_b)  model_grant(m_fuente ? 1 : 2);
        end else begin
            mine  = (m_owner == 1) ? sol_a : sol_b;
            other = (m_owner == 1) ? sol_b : sol_a;
            if (m_held >= T_MIN && other && (!mine || m_held >= T_MAX)) begin
                model_grant(3 - m_owner);
            end else if (m_held >= T_MIN && !mine && !other) begin
                m_owner = 0;
                m_data  = 16'h0;
            end else begin
                m_held = m_held + 1;
                if (mine) m_data = (m_owner == 1) ? datos_a : datos_b;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic go_idle();
        int n;
        sol_a = 1'b0;
        sol_b = 1'b0;
        n = 0;
        while (!apagar && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (apagar !== 1'b1 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL go_idle: got %h required %h after %0d cycles", dut_vec(), model_vec(), n);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        sol_a   = 1'($urandom);
        sol_b   = 1'($urandom);
        datos_a = 16'($urandom);
        datos_b = 16'($urandom);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dut_vec() !== {2'b00, 16'h0000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: got %h required %h", dut_vec(), {2'b00, 16'h0000, 1'b1, 1'b1});
        end
        sol_a = 1'b0;
        sol_b = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (apagar !== 1'b1 || conc_a !== 1'b0 || conc_b !== 1'b0 || dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL reset_idle: got %h required %h", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_single();
        go_idle();
        sol_a   = 1'b1;
        datos_a = 16'h4321;
        step();
        checks++;
        if (conc_a !== 1'b1 || {d3, d2, d1, d0} !== 16'h4321 || apagar !== 1'b0 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL single_grant: got %h required %h", dut_vec(), model_vec());
        end
        datos_a = 16'h0005;
        step();
        checks++;
        if (d0 !== 4'h5 || {d3, d2, d1} !== 12'h000 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL single_live: got %h required %h", dut_vec(), model_vec());
        end
        go_idle();
    endtask

    task automatic test_min_time();
        int n;
        sol_a   = 1'b1;
        datos_a = 16'h0009;
        step();
        sol_a   = 1'b0;
        datos_a = 16'($urandom);
        n = 0;
        while (conc_a && n < 40) begin
            n++;
            checks++;
            if (d0 !== 4'h9 || apagar !== 1'b0 || dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL min_hold_data: got %h required %h", dut_vec(), model_vec());
            end
            step();
        end
        checks++;
        if (n !== T_MIN) begin
            errors++;
            $display("FAIL min_time_len: got %0d cycles required %0d", n, T_MIN);
        end
        checks++;
        if (apagar !== 1'b1 || {d3, d2, d1, d0} !== 16'h0 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL min_time_idle: got %h required %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_preempt();
        int n;
        go_idle();
        sol_a   = 1'b1;
        datos_a = 16'($urandom);
        step();
        sol_b   = 1'b1;
        datos_b = 16'($urandom);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (((k == 0) ? conc_a : conc_b) && n < 100) begin
                n++;
                step();
            end
            checks++;
            if (n !== T_MAX) begin
                errors++;
                $display("FAIL preempt_len_%0d: got %0d cycles required %0d", k, n, T_MAX);
            end
            checks++;
            if (conc_a !== (k == 1) || conc_b !== (k == 0) ||
                {d3, d2, d1, d0} !== ((k == 0) ? datos_b : datos_a) || dut_vec() !== model_vec()) begin
                errors++;
                $display("FAIL preempt_handoff_%0d: got %h required %h", k, dut_vec(), model_vec());
            end
        end
        go_idle();
    endtask

    task automatic test_tie();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
        sol_a   = 1'b1;
        sol_b   = 1'b1;
        datos_a = 16'($urandom);
        datos_b = 16'($urandom);
        step();
        checks++;
        if (conc_a !== 1'b1 || conc_b !== 1'b0 || fuente !== 1'b0 || {d3, d2, d1, d0} !== datos_a) begin
            errors++;
            $display("FAIL tie_first: got %h required %h", dut_vec(), model_vec());
        end
        go_idle();
        sol_a = 1'b1;
        sol_b = 1'b1;
        step();
        checks++;
        if (conc_b !== 1'b1 || conc_a !== 1'b0 || fuente !== 1'b1 || {d3, d2, d1, d0} !== datos_b) begin
            errors++;
            $display("FAIL tie_second: got %h required %h", dut_vec(), model_vec());
        end
        go_idle();
    endtask

    task automatic test_reset_mid();
        go_idle();
        sol_b   = 1'b1;
        datos_b = 16'($urandom);
        step();
        repeat (7) step();
        checks++;
        if (conc_b !== 1'b1 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL reset_mid_setup: got %h required %h", dut_vec(), model_vec());
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (dut_vec() !== {2'b00, 16'h0000, 1'b1, 1'b1} || clk !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_async: got %h required %h", dut_vec(), {2'b00, 16'h0000, 1'b1, 1'b1});
        end
        sol_a   = 1'b1;
        sol_b   = 1'b1;
        datos_a = 16'($urandom);
        #2 rst_n = 1'b1;
        step();
        checks++;
        if (conc_a !== 1'b1 || fuente !== 1'b0 || dut_vec() !== model_vec()) begin
            errors++;
            $display("FAIL reset_mid_tie: got %h required %h", dut_vec(), model_vec());
        end
        go_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            sol_a = ($urandom_range(0, 9) < ((i / 100) % 2 == 0 ? 7 : 3));
            sol_b = ($urandom_range(0, 9) < ((i / 150) % 2 == 0 ? 6 : 2));
            if ($urandom_range(0, 3) == 0) datos_a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) datos_b = 16'($urandom);
            step();
            checks++;
            if (dut_vec() !== model_vec() || (conc_a && conc_b)) begin
                errors++;
                $display("FAIL random_%0d: got %h required %h", i, dut_vec(), model_vec());
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        sol_a   = 1'b0;
        sol_b   = 1'b0;
        datos_a = 16'h0;
        datos_b = 16'h0;
        model_reset();
        test_reset();
        test_single();
        test_min_time();
        test_preempt();
        test_tie();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arbitro_display_7segmentos.md
# arbitro_display_7segmentos

Round-robin arbiter that shares the 4-digit 7-segment display controller between two requesters (A and B). Each requester presents four BCD/hex nibbles and a request line. The arbiter grants the display to one requester at a time, enforces a minimum and maximum display time, and drives the digit buses and a blanking flag into `controlador_display_7segmentos`. It sits directly upstream of that controller, in the same clock domain.

## Interface
- `P_TIEMPO_MIN`, default 4: minimum cycles a granted source keeps the display. Legal range ≥1.
- `P_TIEMPO_MAX`, default 16: cycles after which a source is pre-empted if the other source is requesting. Must be > `P_TIEMPO_MIN`.

- `i_Reloj` in 1: system clock, rising edge.
- `i_Reset` in 1: asynchronous reset, active low.
- `i_Sol_A` in 1: display request, source A.
- `i_Datos_A` in 16: source A digits; [3:0] = digit 0 … [15:12] = digit 3.
- `i_Sol_B` in 1: display request, source B.
- `i_Datos_B` in 16: source B digits, same packing.
- `o_Conc_A` out 1: grant to A (registered).
- `o_Conc_B` out 1: grant to B (registered).
- `o_Datos_0` … `o_Datos_3` out 4 each: digit nibbles to the display controller.
- `o_Apagar` out 1: 1 = display blank (no owner).
- `o_Fuente` out 1: last/current owner; 0 = A, 1 = B.

## Operation
- States: `REPOSO`, `SERVIR_A`, `SERVIR_B`. Grants are decoded from state registers: `o_Conc_A`=(state==`SERVIR_A`), `o_Conc_B`=(state==`SERVIR_B`). The grants are never both 1.
- Hold counter `cnt`:
  - Width `$clog2(P_TIEMPO_MAX+1)`.
  - Cleared to 0 on every entry into a SERVIR state.
  - Increments each cycle in SERVIR and saturates at `P_TIEMPO_MAX-1`.
- `REPOSO` transitions:
  - Only A requests → `SERVIR_A`.
  - Only B requests → `SERVIR_B`.
  - Both request → go to the source that is NOT `o_Fuente`.
  - Neither requests → stay in `REPOSO`.
- `SERVIR_X` transitions, evaluated in priority order:
  1. `cnt < P_TIEMPO_MIN-1` → stay, whatever the requests are.
  2. Other source requesting and (`i_Sol_X`=0 or `cnt ≥ P_TIEMPO_MAX-1`) → `SERVIR_other`.
  3. `i_Sol_X`=0 and other not requesting → `REPOSO`.
  4. Otherwise stay.
- Data register `o_Datos_*`:
  - On the edge that enters `SERVIR_X`, loads `i_Datos_X`.
  - While in `SERVIR_X` with `i_Sol_X`=1, reloads `i_Datos_X` every cycle (live update).
  - While in `SERVIR_X` with `i_Sol_X`=0 (minimum-time tail), holds its value.
  - On entry to `REPOSO`, loads 0.
- `o_Apagar` is registered: 1 in `REPOSO`, 0 in SERVIR states.
- `o_Fuente` is registered: updated on entry to `SERVIR_A` (0) or `SERVIR_B` (1). It keeps its value through `REPOSO`.

## Timing
- Reset values (asynchronous, while `i_Reset`=0): state `REPOSO`, `cnt`=0, `o_Conc_A`=`o_Conc_B`=0, `o_Datos_0..3`=0, `o_Apagar`=1, `o_Fuente`=1. With `o_Fuente`=1, A wins the first tie after reset.
- Latency:
  - Request seen at edge N → grant, data and `o_Apagar`=0 all visible after edge N (one cycle).
  - Live data change on the owner's bus appears on `o_Datos_*` one cycle later.
- Minimum ownership is `P_TIEMPO_MIN` cycles of grant, even if the request drops after one cycle.
- Switch timing:
  - A→B hand-off has no `REPOSO` gap. `o_Conc_A` falls and `o_Conc_B` rises on the same edge.
  - Pre-emption occurs at the edge where `cnt`=`P_TIEMPO_MAX-1`, so the owner holds at most `P_TIEMPO_MAX` cycles while contended.
- Simultaneous events:
  - Release and other-request in the same cycle → direct switch.
  - Both requesting from `REPOSO` → alternate by `o_Fuente`.
- Uncontended owner with request held keeps the display indefinitely. `cnt` stays saturated.
- Reset asserted mid-ownership clears everything immediately, without waiting for a clock edge. After release, the first tie goes to A.

## Test plan
- Reset: `i_Reset`=0 with random inputs → all outputs at reset values. Release reset, no requests → `o_Apagar` stays 1, grants stay 0.
- Single request: `i_Sol_A`=1, `i_Datos_A`=16'h4321 at edge N → after N: `o_Conc_A`=1, `o_Datos_3..0`=4,3,2,1, `o_Apagar`=0. Change `i_Datos_A` to 16'h0005 → `o_Datos_0`=5 one cycle later.
- Minimum time: A requests for 1 cycle only (16'h0009) → `o_Conc_A` high exactly 4 cycles, `o_Datos_0`=9 held throughout, then `REPOSO` with `o_Datos`=0 and `o_Apagar`=1.
- Pre-emption: A held high and B raised one cycle after the A grant → `o_Conc_A` high 16 cycles, then `o_Conc_B`=1 on the same edge `o_Conc_A` falls, and `o_Datos` show B data. With both held, ownership alternates every 16 cycles.
- Tie after reset: `i_Sol_A`=`i_Sol_B`=1 in the same cycle from `REPOSO` → A granted, `o_Fuente`=0. Both release, then both request again → B granted.
- Reset mid-operation: assert `i_Reset` while `SERVIR_B` with `cnt`=7 → outputs reset immediately, before the next edge. On release with both requesting → A granted.
